chunk_feeder: RTL and testbench
===============================

Name: chunk_feeder

Overview:
- Host-side supplier for the chacha streaming-input port of asic_top; sits directly upstream of it.
- Holds key (8 words), nonce (3 words) and counter (1 word) in a local buffer, loaded by the host over a simple write port.
- Answers each chunk_request / request_type / chunk_index from asic_top with a one-cycle chunk_valid pulse carrying the requested word.
- Optionally auto-increments the counter after each completed block, so consecutive blocks need no counter reload.

Parameters:
- KEY_WORDS, 8, number of 32-bit key words
- NONCE_WORDS, 3, number of 32-bit nonce words
- AUTO_INC, 1, 1 = counter increments on block_done; 0 = counter is never modified internally

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_type  in  2  00 key, 01 nonce, 10 counter, 11 illegal (write ignored, err set)
- wr_index  in  3  word index within section
- wr_data  in  32  word to store
- clear  in  1  pulse: drop all loaded flags (buffer contents untouched)
- block_done  in  1  pulse from asic_top done: counter increment request
- chunk_request  in  1  from asic_top
- request_type  in  2  from asic_top, same encoding as wr_type
- chunk_index  in  5  from asic_top
- chunk_valid  out  1  to asic_top, one-cycle pulse
- chunk_type  out  2  to asic_top, echoes the serviced request_type
- chunk  out  32  to asic_top, requested word
- loaded  out  3  {counter, nonce, key} section-complete flags
- starve  out  1  request pending for a section not fully loaded
- err  out  1  sticky: illegal write or illegal request
- ctr_wrap  out  1  sticky: auto-increment wrapped 0xFFFFFFFF to 0

Behaviour:
- Reset: all outputs 0; word-written bits 0; FSM in IDLE; buffer contents undefined (never read before being written).
- Host write: stored on the clk edge where wr_en=1. Sets that word's written bit. A section's loaded bit = AND of its written bits.
  - Out-of-range index (key >7, nonce >2, counter >0) or wr_type 11: no store, err set.
- clear: resets all written bits in that cycle. If wr_en and clear are asserted together, clear wins.
- FSM states: IDLE, SEND, HOLD.
- IDLE:
  - If chunk_request=1 and the (type, index) pair is illegal: set err, stay IDLE, no pulse.
  - If legal but the section is not loaded: starve=1, stay IDLE.
  - Otherwise latch buffer[type][index] into chunk, drive chunk_type, go to SEND.
  - Latency: chunk_valid rises on the edge after the request is first seen.
- SEND: chunk_valid=1 for exactly one cycle. Record the serviced (type, index) pair. Go to HOLD.
- HOLD: no new pulse until chunk_request=0 or (request_type, chunk_index) differs from the recorded pair; then go to IDLE. Same-cycle re-evaluation is not required. This guarantees one pulse per requested word.
- Data coherence: the value sent is the buffer content at the latch cycle. A host write to the same word in that cycle is not reflected; the new value is stored for later requests.
- starve: combinational; 1 only in IDLE while a legal request targets an unloaded section.
- Counter auto-increment (AUTO_INC=1): on block_done, counter <= counter+1 mod 2^32. 0xFFFFFFFF -> 0 sets ctr_wrap.
  - A host counter write in the same cycle as block_done wins; no increment, no wrap.
  - block_done during SEND or HOLD of a counter word does not alter the word already latched in chunk.
- err and ctr_wrap clear only on rst.
- rst mid-operation: FSM forced to IDLE; chunk_valid forced 0 on the same edge.

Decomposition:
- Shared package chacha_stream_pkg: chunk-type encoding enum (KEY=00, NONCE=01, COUNTER=10), section word counts, FSM state enum. asic_top and testbenches import the same package.
- One natural sub-module, feeder_buffer: 12x32 register file with written bits, loaded flags and the counter incrementer. The top holds the FSM and range checking.

Test Plan:
- Load key 0x40000000..07, nonce 0x50000000..02, counter 0x60000000, then drive the asic_top all-streamed request sequence -> exactly 12 chunk_valid pulses, data and type matching each request index, no err.
- Hold chunk_request=1 with type 00, index 3 for 10 cycles -> exactly one pulse carrying key word 3, then silence.
- Load the key only, then request nonce index 0 -> starve=1 with no pulse; write the 3 nonce words -> pulse one cycle after the last word is written.
- Request key index 9, then type 11 -> err=1, no pulse; err stays set through later valid traffic.
- Counter=0xFFFFFFFE, two block_done pulses -> counter reads 0xFFFFFFFF then 0x00000000, ctr_wrap=1. block_done together with a counter write of 0x5 -> counter=0x5.
- Assert rst during SEND -> chunk_valid=0 on the next edge, loaded=000, FSM IDLE; a request after reset gives starve=1.

Source files
------------

// File: rtl/chacha_stream_pkg.sv
// Shared definitions for the chacha streaming-input link: chunk-type encoding,
// section word counts and the feeder FSM state encoding.
package chacha_stream_pkg;

  typedef enum logic [1:0] {
    CT_KEY     = 2'b00,
    CT_NONCE   = 2'b01,
    CT_COUNTER = 2'b10,
    CT_ILLEGAL = 2'b11
  } chunk_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } feeder_state_e;

  localparam int unsigned KEY_WORDS_DEF   = 8;
  localparam int unsigned NONCE_WORDS_DEF = 3;
  localparam int unsigned COUNTER_WORDS   = 1;
  localparam int unsigned WORD_W          = 32;

endpackage

// File: rtl/feeder_buffer.sv
// Key/nonce/counter register file with per-word written bits, section loaded
// flags and the block counter incrementer.
module feeder_buffer
  import chacha_stream_pkg::*;
#(
  parameter int unsigned KEY_WORDS   = KEY_WORDS_DEF,
  parameter int unsigned NONCE_WORDS = NONCE_WORDS_DEF,
  parameter bit          AUTO_INC    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_type,
  input  logic [4:0]        wr_index,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              clear,
  input  logic              block_done,
  input  logic [1:0]        rd_type,
  input  logic [4:0]        rd_index,
  output logic [WORD_W-1:0] rd_data,
  output logic [2:0]        loaded,
  output logic              ctr_wrap
);

  localparam int unsigned KIW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int unsigned NIW = (NONCE_WORDS > 1) ? $clog2(NONCE_WORDS) : 1;
  localparam logic [4:0] KEY_LIM   = 5'(KEY_WORDS);
  localparam logic [4:0] NONCE_LIM = 5'(NONCE_WORDS);

  logic [WORD_W-1:0]      key_q   [KEY_WORDS];
  logic [WORD_W-1:0]      key_d   [KEY_WORDS];
  logic [WORD_W-1:0]      nonce_q [NONCE_WORDS];
  logic [WORD_W-1:0]      nonce_d [NONCE_WORDS];
  logic [WORD_W-1:0]      ctr_q, ctr_d;
  logic [KEY_WORDS-1:0]   key_wr_q, key_wr_d;
  logic [NONCE_WORDS-1:0] nonce_wr_q, nonce_wr_d;
  logic                   ctr_wr_q, ctr_wr_d;
  logic                   ctr_wrap_q, ctr_wrap_d;
  logic                   key_hit, nonce_hit, ctr_hit;

  // NOTE: every always_comb output is given a default first, so no latch is inferred.
  always_comb begin
    key_hit   = wr_en && (wr_type == CT_KEY)     && (wr_index < KEY_LIM);
    nonce_hit = wr_en && (wr_type == CT_NONCE)   && (wr_index < NONCE_LIM);
    ctr_hit   = wr_en && (wr_type == CT_COUNTER) && (wr_index == 5'd0);

    key_d   = key_q;
    nonce_d = nonce_q;
    if (key_hit)   key_d[wr_index[KIW-1:0]]   = wr_data;
    if (nonce_hit) nonce_d[wr_index[NIW-1:0]] = wr_data;

    // A host counter write takes priority over the block-done increment.
    ctr_d      = ctr_q;
    ctr_wrap_d = ctr_wrap_q;
    if (ctr_hit) begin
      ctr_d = wr_data;
    end else if (AUTO_INC && block_done) begin
      ctr_d = ctr_q + 32'd1;
      if (ctr_q == '1) ctr_wrap_d = 1'b1;
    end

    key_wr_d   = key_wr_q;
    nonce_wr_d = nonce_wr_q;
    ctr_wr_d   = ctr_wr_q;
    if (clear) begin
      key_wr_d   = '0;
      nonce_wr_d = '0;
      ctr_wr_d   = 1'b0;
    end else begin
      if (key_hit)   key_wr_d[wr_index[KIW-1:0]]   = 1'b1;
      if (nonce_hit) nonce_wr_d[wr_index[NIW-1:0]] = 1'b1;
      if (ctr_hit)   ctr_wr_d = 1'b1;
    end
  end

  // NOTE: the word storage has no reset; the written bits gate every read, so
  // contents are never observed before the host has written them.
  always_ff @(posedge clk) begin
    key_q   <= key_d;
    nonce_q <= nonce_d;
    ctr_q   <= ctr_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_wr_q   <= '0;
      nonce_wr_q <= '0;
      ctr_wr_q   <= 1'b0;
      ctr_wrap_q <= 1'b0;
    end else begin
      key_wr_q   <= key_wr_d;
      nonce_wr_q <= nonce_wr_d;
      ctr_wr_q   <= ctr_wr_d;
      ctr_wrap_q <= ctr_wrap_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_type)
      CT_KEY:     if (rd_index < KEY_LIM)   rd_data = key_q[rd_index[KIW-1:0]];
      CT_NONCE:   if (rd_index < NONCE_LIM) rd_data = nonce_q[rd_index[NIW-1:0]];
      CT_COUNTER: if (rd_index == 5'd0)     rd_data = ctr_q;
      default:    rd_data = '0;
    endcase
  end

  assign loaded   = {ctr_wr_q, &nonce_wr_q, &key_wr_q};
  assign ctr_wrap = ctr_wrap_q;

endmodule

// File: rtl/chunk_feeder.sv
// Host-side supplier for the chacha streaming-input port: answers each word
// request with a single chunk_valid pulse once the requested section is loaded.
module chunk_feeder
  import chacha_stream_pkg::*;
#(
  parameter int unsigned KEY_WORDS   = KEY_WORDS_DEF,
  parameter int unsigned NONCE_WORDS = NONCE_WORDS_DEF,
  parameter bit          AUTO_INC    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_type,
  input  logic [2:0]  wr_index,
  input  logic [31:0] wr_data,
  input  logic        clear,
  input  logic        block_done,
  input  logic        chunk_request,
  input  logic [1:0]  request_type,
  input  logic [4:0]  chunk_index,
  output logic        chunk_valid,
  output logic [1:0]  chunk_type,
  output logic [31:0] chunk,
  output logic [2:0]  loaded,
  output logic        starve,
  output logic        err,
  output logic        ctr_wrap
);

  localparam logic [4:0] KEY_LIM   = 5'(KEY_WORDS);
  localparam logic [4:0] NONCE_LIM = 5'(NONCE_WORDS);

  function automatic logic pair_legal(input logic [1:0] t, input logic [4:0] idx);
    case (t)
      CT_KEY:     return idx < KEY_LIM;
      CT_NONCE:   return idx < NONCE_LIM;
      CT_COUNTER: return idx == 5'd0;
      default:    return 1'b0;
    endcase
  endfunction

  feeder_state_e state_q, state_d;
  logic [31:0]   chunk_q, chunk_d;
  logic [1:0]    chunk_type_q, chunk_type_d;
  logic [4:0]    rec_index_q, rec_index_d;
  logic          err_q, err_d;
  logic [31:0]   rd_data;
  logic          wr_legal, req_legal, sect_loaded, pair_same;

  feeder_buffer #(
    .KEY_WORDS  (KEY_WORDS),
    .NONCE_WORDS(NONCE_WORDS),
    .AUTO_INC   (AUTO_INC)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en && wr_legal && !clear),
    .wr_type   (wr_type),
    .wr_index  ({2'b00, wr_index}),
    .wr_data   (wr_data),
    .clear     (clear),
    .block_done(block_done),
    .rd_type   (request_type),
    .rd_index  (chunk_index),
    .rd_data   (rd_data),
    .loaded    (loaded),
    .ctr_wrap  (ctr_wrap)
  );

  always_comb begin
    wr_legal  = pair_legal(wr_type, {2'b00, wr_index});
    req_legal = pair_legal(request_type, chunk_index);
    case (request_type)
      CT_KEY:     sect_loaded = loaded[0];
      CT_NONCE:   sect_loaded = loaded[1];
      CT_COUNTER: sect_loaded = loaded[2];
      default:    sect_loaded = 1'b0;
    endcase
    pair_same = (request_type == chunk_type_q) && (chunk_index == rec_index_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (chunk_request && req_legal && sect_loaded) state_d = ST_SEND;
      ST_SEND: state_d = ST_HOLD;
      // Stay here while the same word is still being asked for: one pulse per word.
      ST_HOLD: if (!chunk_request || !pair_same) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    chunk_valid = (state_q == ST_SEND);
    starve      = (state_q == ST_IDLE) && chunk_request && req_legal && !sect_loaded;
  end

  // The word and its (type, index) pair are captured together at the latch cycle.
  always_comb begin
    chunk_d      = chunk_q;
    chunk_type_d = chunk_type_q;
    rec_index_d  = rec_index_q;
    if (state_q == ST_IDLE && state_d == ST_SEND) begin
      chunk_d      = rd_data;
      chunk_type_d = request_type;
      rec_index_d  = chunk_index;
    end
    err_d = err_q
          | (wr_en && !wr_legal)
          | ((state_q == ST_IDLE) && chunk_request && !req_legal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_q      <= '0;
      chunk_type_q <= '0;
      rec_index_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      chunk_q      <= chunk_d;
      chunk_type_q <= chunk_type_d;
      rec_index_q  <= rec_index_d;
      err_q        <= err_d;
    end
  end

  assign chunk      = chunk_q;
  assign chunk_type = chunk_type_q;
  assign err        = err_q;

endmodule

// File: tb/tb_chunk_feeder.sv
// Randomised self-checking bench for chunk_feeder against a word-level model
// of the key/nonce/counter buffer and its request protocol.
module tb_chunk_feeder;
  import chacha_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst, wr_en, clear, block_done, chunk_request;
  logic [1:0]  wr_type, request_type;
  logic [2:0]  wr_index;
  logic [31:0] wr_data;
  logic [4:0]  chunk_index;
  logic        chunk_valid, starve, err, ctr_wrap;
  logic [1:0]  chunk_type;
  logic [31:0] chunk;
  logic [2:0]  loaded;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_key [8];
  logic [31:0] m_nonce [3];
  logic [31:0] m_ctr;
  bit   [7:0]  m_wk;
  bit   [2:0]  m_wn;
  bit          m_wc, m_err, m_wrap;

  int          pulses, total_pulses;
  logic [31:0] last_chunk;
  logic [1:0]  last_type;

  chunk_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_type(wr_type), .wr_index(wr_index),
    .wr_data(wr_data), .clear(clear), .block_done(block_done),
    .chunk_request(chunk_request), .request_type(request_type), .chunk_index(chunk_index),
    .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk(chunk), .loaded(loaded),
    .starve(starve), .err(err), .ctr_wrap(ctr_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m_loaded();
    return {m_wc, &m_wn, &m_wk};
  endfunction

  function automatic bit legal(input logic [1:0] t, input int idx);
    return (t == 2'd0 && idx < 8) || (t == 2'd1 && idx < 3) || (t == 2'd2 && idx == 0);
  endfunction

  function automatic logic [31:0] m_word(input logic [1:0] t, input int idx);
    case (t)
      2'd0:    return m_key[idx];
      2'd1:    return m_nonce[idx];
      default: return m_ctr;
    endcase
  endfunction

  // One clock: apply the model's view of the inputs at the edge, then sample.
  task automatic step();
    bit ctr_written;
    @(posedge clk);
    ctr_written = 1'b0;
    if (rst) begin
      m_wk = '0; m_wn = '0; m_wc = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
    end else begin
      if (wr_en) begin
        if (!legal(wr_type, int'(wr_index))) m_err = 1'b1;
        else if (!clear) begin
          case (wr_type)
            2'd0: begin m_key[wr_index] = wr_data; m_wk[wr_index] = 1'b1; end
            2'd1: begin m_nonce[wr_index] = wr_data; m_wn[wr_index] = 1'b1; end
            default: begin m_ctr = wr_data; m_wc = 1'b1; ctr_written = 1'b1; end
          endcase
        end
      end
      if (block_done && !ctr_written) begin
        if (m_ctr == 32'hFFFF_FFFF) m_wrap = 1'b1;
        m_ctr = m_ctr + 32'd1;
      end
      if (clear) begin m_wk = '0; m_wn = '0; m_wc = 1'b0; end
      if (chunk_request && !legal(request_type, int'(chunk_index))) m_err = 1'b1;
    end
    #1;
    if (chunk_valid) begin
      pulses++;
      total_pulses++;
      last_chunk = chunk;
      last_type  = chunk_type;
    end
  endtask

  task automatic host_write(input logic [1:0] t, input int idx, input logic [31:0] data);
    wr_en = 1'b1; wr_type = t; wr_index = 3'(idx); wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic release_request();
    chunk_request = 1'b0;
    step();
    step();
  endtask

  // Hold a request for a bounded number of cycles; expect exactly one pulse.
  task automatic do_request(input logic [1:0] t, input int idx, input int hold, input string tag);
    logic [31:0] exp;
    exp = m_word(t, idx);
    chunk_request = 1'b1; request_type = t; chunk_index = 5'(idx);
    pulses = 0;
    repeat (hold) step();
    release_request();
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " data"}, last_chunk, exp);
    check({tag, " type"}, 32'(last_type), 32'(t));
  endtask

  task automatic check_status(input string tag);
    check({tag, " loaded"}, 32'(loaded), 32'(m_loaded()));
    check({tag, " err"}, 32'(err), 32'(m_err));
    check({tag, " ctr_wrap"}, 32'(ctr_wrap), 32'(m_wrap));
  endtask

  initial begin
    logic [31:0] old_word;
    logic [1:0]  rt;
    int          ri;

    rst = 1'b1; wr_en = 1'b0; wr_type = '0; wr_index = '0; wr_data = '0;
    clear = 1'b0; block_done = 1'b0; chunk_request = 1'b0; request_type = '0; chunk_index = '0;
    pulses = 0; total_pulses = 0; last_chunk = '0; last_type = '0;
    step(); step();
    rst = 1'b0;
    check("reset chunk_valid", 32'(chunk_valid), 32'd0);
    check("reset chunk", chunk, 32'd0);
    check("reset chunk_type", 32'(chunk_type), 32'd0);
    check("reset starve", 32'(starve), 32'd0);
    check_status("reset");

    // clear and a write in the same cycle: clear wins
    wr_en = 1'b1; wr_type = 2'd2; wr_index = 3'd0; wr_data = 32'h1234_5678; clear = 1'b1;
    step();
    wr_en = 1'b0; clear = 1'b0;
    check_status("clear+write");

    // Load everything and stream the 12 words as asic_top would
    for (int i = 0; i < 8; i++) host_write(2'd0, i, 32'h4000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) host_write(2'd1, i, 32'h5000_0000 + 32'(i));
    host_write(2'd2, 0, 32'h6000_0000);
    check_status("loaded all");
    total_pulses = 0;
    for (int i = 0; i < 8; i++) do_request(2'd0, i, 3, $sformatf("stream key%0d", i));
    for (int i = 0; i < 3; i++) do_request(2'd1, i, 3, $sformatf("stream nonce%0d", i));
    do_request(2'd2, 0, 3, "stream ctr");
    check("stream total pulses", 32'(total_pulses), 32'd12);
    check_status("stream");

    do_request(2'd0, 3, 10, "hold10 key3");

    // Host write racing the latch: the old word is sent, the new one is kept
    old_word = m_key[5];
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd5; pulses = 0;
    wr_en = 1'b1; wr_type = 2'd0; wr_index = 3'd5; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    step(); step();
    release_request();
    check("coherence pulses", 32'(pulses), 32'd1);
    check("coherence old data", last_chunk, old_word);
    do_request(2'd0, 5, 3, "coherence new data");

    // Starve: key only, nonce requested
    clear = 1'b1; step(); clear = 1'b0;
    check_status("after clear");
    for (int i = 0; i < 8; i++) host_write(2'd0, i, $urandom);
    chunk_request = 1'b1; request_type = 2'd1; chunk_index = 5'd0; pulses = 0;
    #1;
    check("starve asserted", 32'(starve), 32'd1);
    repeat (3) step();
    check("starve no pulse", 32'(pulses), 32'd0);
    check("starve held", 32'(starve), 32'd1);
    for (int i = 0; i < 3; i++) host_write(2'd1, i, $urandom);
    check("starve released", 32'(starve), 32'd0);
    check("no pulse on load edge", 32'(pulses), 32'd0);
    step();
    check("pulse after load", 32'(pulses), 32'd1);
    check("pulse after load data", last_chunk, m_nonce[0]);
    release_request();

    // Counter increment and wrap
    host_write(2'd2, 0, 32'hFFFF_FFFE);
    block_done = 1'b1; step(); block_done = 1'b0;
    do_request(2'd2, 0, 3, "ctr inc1");
    check_status("ctr inc1");
    block_done = 1'b1; step(); block_done = 1'b0;
    do_request(2'd2, 0, 3, "ctr wrap");
    check_status("ctr wrap");
    wr_en = 1'b1; wr_type = 2'd2; wr_index = 3'd0; wr_data = 32'h5; block_done = 1'b1;
    step();
    wr_en = 1'b0; block_done = 1'b0;
    do_request(2'd2, 0, 3, "ctr write wins");
    check_status("ctr write wins");
    // block_done while the counter word is held does not disturb it
    chunk_request = 1'b1; request_type = 2'd2; chunk_index = 5'd0; pulses = 0;
    step(); step();
    block_done = 1'b1; step(); block_done = 1'b0;
    check("ctr held chunk", chunk, 32'h5);
    release_request();
    do_request(2'd2, 0, 3, "ctr after held inc");

    // Illegal requests
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd9; pulses = 0;
    repeat (3) step();
    check("illegal idx pulses", 32'(pulses), 32'd0);
    release_request();
    chunk_request = 1'b1; request_type = 2'd3; chunk_index = 5'd0; pulses = 0;
    repeat (3) step();
    check("illegal type pulses", 32'(pulses), 32'd0);
    release_request();
    check_status("illegal req");
    do_request(2'd0, 1, 3, "after illegal");
    check_status("err sticky");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      rt = 2'($urandom_range(0, 2));
      ri = (rt == 2'd0) ? $urandom_range(0, 7) : (rt == 2'd1) ? $urandom_range(0, 2) : 0;
      block_done = ($urandom_range(0, 3) == 0);
      host_write(rt, ri, $urandom);
      block_done = 1'b0;
      rt = 2'($urandom_range(0, 2));
      ri = (rt == 2'd0) ? $urandom_range(0, 7) : (rt == 2'd1) ? $urandom_range(0, 2) : 0;
      do_request(rt, ri, $urandom_range(2, 5), $sformatf("rand%0d", n));
      check_status($sformatf("rand%0d", n));
    end

    // Reset during SEND
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd2; pulses = 0;
    step();
    check("send before rst", 32'(chunk_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst kills valid", 32'(chunk_valid), 32'd0);
    check("rst chunk", chunk, 32'd0);
    check_status("rst mid-op");
    #1;
    check("starve after rst", 32'(starve), 32'd1);
    pulses = 0;
    repeat (2) step();
    check("no pulse after rst", 32'(pulses), 32'd0);
    release_request();

    // Illegal host writes after reset
    host_write(2'd1, 5, 32'h1);
    host_write(2'd3, 0, 32'h2);
    check_status("illegal write");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
